// File: rtl/nn_act_pkg.sv
// Shared constants and helpers for the LUT interpolating activation unit:
// default table contents, next-entry index selection and the rounding constant.
package nn_act_pkg;

    localparam int DEF_DEPTH = 16;

    localparam logic signed [7:0] DEF_LUT [DEF_DEPTH] = '{
        8'sd0,   8'sd12,  8'sd15,  8'sd15,  8'sd15,  8'sd15,  8'sd15,  8'sd15,
        -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd15, -8'sd12
    };

    function automatic logic signed [7:0] def_entry(input int i);
        return DEF_LUT[i % DEF_DEPTH];
    endfunction

    // The most positive signed index never interpolates across the sign jump;
    // index -1 interpolates toward entry 0; the unsigned top entry clamps.
    function automatic int next_idx(input int i, input int signed_idx, input int addr_w);
        int top;
        top = (1 << addr_w) - 1;
        if (signed_idx != 0 && i == (top >> 1))
            return i;
        if (i == top)
            return (signed_idx != 0) ? 0 : i;
        return i + 1;
    endfunction

    function automatic logic signed [31:0] round_const(input int frac_w);
        return 32'sd1 <<< (frac_w - 1);
    endfunction

endpackage

// File: rtl/lut_interp_table.sv
// Activation table storage with base/next combinational read.
// With LUT_WRITE_EN the table is a writable register array reset to DEF_LUT; otherwise a constant ROM.
module lut_interp_table
    import nn_act_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int SIGNED_IDX = 1
) (
`ifdef LUT_WRITE_EN
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] wdata,
`endif
    input  logic [ADDR_W-1:0]        rd_idx,
    output logic signed [DATA_W-1:0] base,
    output logic signed [DATA_W-1:0] next
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] nxt_idx;

    always_comb begin
        nxt_idx = ADDR_W'(next_idx(int'(rd_idx), SIGNED_IDX, ADDR_W));
    end

`ifdef LUT_WRITE_EN
    logic signed [DATA_W-1:0] lut_q [DEPTH];
    logic signed [DATA_W-1:0] lut_d [DEPTH];

    // Reads see lut_q, so a write lands after any same-cycle read.
    always_comb begin
        lut_d = lut_q;
        if (we)
            lut_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                lut_q[k] <= DATA_W'(def_entry(k));
        end else begin
            lut_q <= lut_d;
        end
    end

    assign base = lut_q[rd_idx];
    assign next = lut_q[nxt_idx];
`else
    logic signed [DATA_W-1:0] rom [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            rom[k] = DATA_W'(def_entry(k));
    end

    assign base = rom[rd_idx];
    assign next = rom[nxt_idx];
`endif

endmodule

// File: rtl/lut_interp_activation.sv
// Three-stage LUT lookup + linear interpolation activation with valid/ready on both sides.
// Define LUT_WRITE_EN to add the tbl_* runtime table write port.
module lut_interp_activation
    import nn_act_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int FRAC_W     = 4,
    parameter int DATA_W     = 8,
    parameter int SIGNED_IDX = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W+FRAC_W-1:0] in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_y
`ifdef LUT_WRITE_EN
    ,
    input  logic                     tbl_we,
    input  logic [ADDR_W-1:0]        tbl_waddr,
    input  logic [DATA_W-1:0]        tbl_wdata
`endif
);

    localparam int IN_W = ADDR_W + FRAC_W;
    localparam int DW1  = DATA_W + 1;
    localparam int PW   = DATA_W + FRAC_W + 2;

    logic signed [DATA_W-1:0] tbl_base, tbl_next;

    lut_interp_table #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SIGNED_IDX(SIGNED_IDX)
    ) u_table (
`ifdef LUT_WRITE_EN
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
`endif
        .rd_idx(in_x[IN_W-1:FRAC_W]),
        .base  (tbl_base),
        .next  (tbl_next)
    );

    logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [DATA_W-1:0] base1_q, base1_d, next1_q, next1_d;
    logic [FRAC_W-1:0]        frac1_q, frac1_d;
    logic signed [DATA_W-1:0] base2_q, base2_d;
    logic signed [PW-1:0]     p2_q, p2_d;
    logic [DATA_W-1:0]        y3_q, y3_d;
    logic                     ld1, ld2, ld3;
    logic signed [DW1-1:0]    diff;
    logic signed [PW-1:0]     sum;

    // Handshake: a transfer happens on any edge where valid && ready. Stage k
    // loads whenever stage k+1 is empty or draining, so bubbles collapse and
    // in_ready is a combinational function of out_ready and the stage valids.
    assign ld3       = !v3_q || out_ready;
    assign ld2       = !v2_q || ld3;
    assign ld1       = !v1_q || ld2;
    assign in_ready  = ld1;
    assign out_valid = v3_q;
    assign out_y     = y3_q;

    always_comb begin
        v1_d    = v1_q;
        base1_d = base1_q;
        next1_d = next1_q;
        frac1_d = frac1_q;
        v2_d    = v2_q;
        base2_d = base2_q;
        p2_d    = p2_q;
        v3_d    = v3_q;
        y3_d    = y3_q;
        diff    = DW1'(next1_q) - DW1'(base1_q);
        sum     = PW'(base2_q) + ((p2_q + PW'(round_const(FRAC_W))) >>> FRAC_W);

        if (ld1) begin
            v1_d    = in_valid;
            base1_d = tbl_base;
            next1_d = tbl_next;
            frac1_d = in_x[FRAC_W-1:0];
        end
        if (ld2) begin
            v2_d    = v1_q;
            base2_d = base1_q;
            p2_d    = PW'(diff) * PW'($signed({1'b0, frac1_q}));
        end
        // y always lies between base and next, so truncation never wraps.
        if (ld3) begin
            v3_d = v2_q;
            y3_d = sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            base1_q <= '0;
            next1_q <= '0;
            frac1_q <= '0;
            v2_q    <= 1'b0;
            base2_q <= '0;
            p2_q    <= '0;
            v3_q    <= 1'b0;
            y3_q    <= '0;
        end else begin
            v1_q    <= v1_d;
            base1_q <= base1_d;
            next1_q <= next1_d;
            frac1_q <= frac1_d;
            v2_q    <= v2_d;
            base2_q <= base2_d;
            p2_q    <= p2_d;
            v3_q    <= v3_d;
            y3_q    <= y3_d;
        end
    end

endmodule

// File: tb/tb_lut_interp_activation.sv
// Self-checking bench for lut_interp_activation: directed vectors, stalls, random traffic,
// optional table writes (LUT_WRITE_EN) and asynchronous reset with items in flight.
module tb_lut_interp_activation;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_y;
`ifdef LUT_WRITE_EN
    logic       tbl_we = 1'b0;
    logic [3:0] tbl_waddr = 4'h0;
    logic [7:0] tbl_wdata = 8'h00;
`endif

    lut_interp_activation dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y)
`ifdef LUT_WRITE_EN
        ,
        .tbl_we   (tbl_we),
        .tbl_waddr(tbl_waddr),
        .tbl_wdata(tbl_wdata)
`endif
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_out = 0;
    logic [7:0] exp_q[$];
    int         acc_q[$];
    bit         check_lat = 1'b0;
    bit         saw_full = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_y = 8'h00;
    logic [7:0] last_y = 8'h00;
    int         model_lut[16];

    function automatic void load_def();
        model_lut = '{0, 12, 15, 15, 15, 15, 15, 15, -15, -15, -15, -15, -15, -15, -15, -12};
    endfunction

    // Reference: pick neighbour by the table rules, interpolate with exact
    // integer arithmetic and round half toward +inf.
    function automatic logic [7:0] model_y(input logic [7:0] x);
        int i, f, b, n, num, fl;
        i = int'(x[7:4]);
        f = int'(x[3:0]);
        b = model_lut[i];
        if (i == 7)       n = b;
        else if (i == 15) n = model_lut[0];
        else              n = model_lut[i + 1];
        num = (n - b) * f + 8;
        fl  = (num >= 0) ? (num / 16) : -((-num + 15) / 16);
        return 8'(b + fl);
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
            load_def();
        end else begin
            if (prev_stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_y !== prev_y) begin
                    n_fail++;
                    $display("FAIL stall_hold: out_valid=%b out_y=%h, required 1 and %h", out_valid, out_y, prev_y);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            if (out_valid && out_ready) begin
                n_out++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: out_y=%h with nothing outstanding", out_y);
                end else begin
                    logic [7:0] e;
                    int a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    last_y = out_y;
                    if (out_y !== e) begin
                        n_fail++;
                        $display("FAIL out_y: got %h, required %h", out_y, e);
                    end
                    if (check_lat) begin
                        n_tests++;
                        if (cyc - a != 3) begin
                            n_fail++;
                            $display("FAIL latency: got %0d cycles, required 3", cyc - a);
                        end
                    end
                end
            end
            if (in_valid && !in_ready)
                saw_full = 1'b1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_y(in_x));
                acc_q.push_back(cyc);
            end
`ifdef LUT_WRITE_EN
            if (tbl_we)
                model_lut[tbl_waddr] = $signed(tbl_wdata);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x);
        bit acc;
        int guard;
        in_valid = 1'b1;
        in_x     = x;
        guard    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        in_valid = 1'b0;
        n_tests++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_y !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: out_valid=%b out_y=%h, required 0 and 00", out_valid, out_y);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] xs [4];
        logic [7:0] ys [4];
        xs = '{8'h10, 8'h08, 8'h7F, 8'hF8};
        ys = '{8'd12, 8'd6, 8'd15, 8'hFA};
        out_ready = 1'b1;
        check_lat = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(xs[k]);
            wait_drain();
            n_tests++;
            if (last_y !== ys[k]) begin
                n_fail++;
                $display("FAIL vector_%h: got %h, required %h", xs[k], last_y, ys[k]);
            end
        end
        check_lat = 1'b0;
    endtask

    task automatic test_stall();
        int start;
        start     = n_out;
        saw_full  = 1'b0;
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(8'($urandom_range(0, 255)));
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 4 && c <= 7);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        n_tests++;
        if (n_out - start != 8) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, required 8", n_out - start);
        end
        n_tests++;
        if (!saw_full) begin
            n_fail++;
            $display("FAIL stall_backpressure: in_ready never dropped, required a drop");
        end
    endtask

    task automatic test_back_to_back_random();
        bit done;
        int start;
        done  = 1'b0;
        start = n_out;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    send(8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 2)) tick();
                end
                done = 1'b1;
            end
            begin
                int c;
                c = 0;
                while (!done && c < 3000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                    c++;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        n_tests++;
        if (n_out - start != 150) begin
            n_fail++;
            $display("FAIL random_count: got %0d results, required 150", n_out - start);
        end
    endtask

`ifdef LUT_WRITE_EN
    task automatic test_table_write();
        out_ready = 1'b1;
        tbl_waddr = 4'd1;
        tbl_wdata = 8'h9C;
        tbl_we    = 1'b1;
        send(8'h10);
        tbl_we    = 1'b0;
        wait_drain();
        n_tests++;
        if (last_y !== 8'd12) begin
            n_fail++;
            $display("FAIL write_same_cycle: got %h, required 0c", last_y);
        end
        send(8'h10);
        wait_drain();
        n_tests++;
        if (last_y !== 8'h9C) begin
            n_fail++;
            $display("FAIL write_visible: got %h, required 9c", last_y);
        end
    endtask
`endif

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            send(8'($urandom_range(0, 255)));
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_setup: out_valid=%b, required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_y !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%b out_y=%h, required 0 and 00", out_valid, out_y);
        end
        exp_q.delete();
        acc_q.delete();
        load_def();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++)
            send({4'(i), 4'h0});
        wait_drain();
        n_tests++;
        if (last_y !== 8'hF4) begin
            n_fail++;
            $display("FAIL table_after_reset: lut[15] read %h, required f4", last_y);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_def();
        test_reset();
        test_vectors();
        test_stall();
        test_back_to_back_random();
`ifdef LUT_WRITE_EN
        test_table_write();
`endif
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
